pipeline_stall_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Merges the load-use stall from hazard

---
 rtl/cpu_ctrl_pkg.sv | 9 +
 rtl/mdu_cycle_counter.sv | 19 +
 rtl/pipeline_stall_controller.sv | 128 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings and default MDU latencies for the pipeline stall controller.
package cpu_ctrl_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_MDU, ST_HALT} state_t;
    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_EXC = 2'd2;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 8;
endpackage

// File: rtl/mdu_cycle_counter.sv
// mdu_cycle_counter: loadable down-counter that tracks remaining MDU freeze cycles.
module mdu_cycle_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] init,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= init;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: priority-resolved stall/flush/PC-select sequencer for the 5-stage pipeline.
module pipeline_stall_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hd_stall,
    input  logic       ex_branch_taken,
    input  logic       ex_overflow,
    input  logic       ex_mdu_start,
    input  logic       ex_mdu_is_div,
    input  logic       id_halt,
    input  logic       resume,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_flush,
    output logic       ex_mem_bubble,
    output logic [1:0] pc_sel,
    output logic       mdu_done,
    output logic       halted,
    output logic       exc_flag
);
    state_t state, state_nx;
    logic cnt_load, cnt_dec, cnt_zero, exc_set;
    logic [CNT_W-1:0] cnt_init;

    // The start cycle is itself a freeze cycle, so the counter holds N-2 remaining freezes.
    assign cnt_init = ex_mdu_is_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);

    mdu_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .load (cnt_load),
        .dec  (cnt_dec),
        .init (cnt_init),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            exc_flag <= 1'b0;
        end else begin
            state <= state_nx;
            if (exc_set) exc_flag <= 1'b1;
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        pc_sel        = PC_SEQ;
        mdu_done      = 1'b0;
        halted        = 1'b0;
        state_nx      = state;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        exc_set       = 1'b0;
        case (state)
            ST_RUN: begin
                if (ex_overflow) begin
                    pc_sel        = PC_EXC;
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    ex_mem_bubble = 1'b1;
                    exc_set       = 1'b1;
                end else if (ex_branch_taken) begin
                    pc_sel      = PC_BR;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ex_mdu_start) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    cnt_load      = 1'b1;
                    state_nx      = ST_MDU;
                end else if (id_halt || hd_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    if (id_halt) state_nx = ST_HALT;
                end
            end
            ST_MDU: begin
                if (!cnt_zero) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    cnt_dec       = 1'b1;
                end else begin
                    mdu_done = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_HALT: begin
                halted      = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (resume) state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
            pc_sel        = PC_SEQ;
            mdu_done      = 1'b0;
            halted        = 1'b0;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: table-driven directed bench for the stall/flush sequencer.
module tb_pipeline_stall_controller;
    logic clk = 1'b0;
    logic rst_n, hd_stall, ex_branch_taken, ex_overflow, ex_mdu_start, ex_mdu_is_div, id_halt, resume;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, mdu_done, halted, exc_flag;
    logic [1:0] pc_sel;

    always #5 clk = ~clk;

    pipeline_stall_controller dut (
        .clk(clk), .rst_n(rst_n), .hd_stall(hd_stall), .ex_branch_taken(ex_branch_taken),
        .ex_overflow(ex_overflow), .ex_mdu_start(ex_mdu_start), .ex_mdu_is_div(ex_mdu_is_div),
        .id_halt(id_halt), .resume(resume), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble), .pc_sel(pc_sel), .mdu_done(mdu_done), .halted(halted),
        .exc_flag(exc_flag)
    );

    // inputs: {rst_n, hd, br, ov, start, div, halt, resume}
    // outputs: {pc_w, if_id_w, if_id_fl, id_ex_w, id_ex_fl, bubble, pc_sel[1:0], done, halted}
    typedef struct packed {
        logic [7:0] in;
        logic [9:0] o;
        logic       e;
    } vec_t;

    localparam logic [9:0] O_RST  = 10'b0_0_1_0_1_1_00_0_0;
    localparam logic [9:0] O_RUN  = 10'b1_1_0_1_0_0_00_0_0;
    localparam logic [9:0] O_EXC  = 10'b1_1_1_1_1_1_10_0_0;
    localparam logic [9:0] O_BR   = 10'b1_1_1_1_1_0_01_0_0;
    localparam logic [9:0] O_FRZ  = 10'b0_0_0_0_0_1_00_0_0;
    localparam logic [9:0] O_DONE = 10'b1_1_0_1_0_0_00_1_0;
    localparam logic [9:0] O_STL  = 10'b0_0_0_1_1_0_00_0_0;
    localparam logic [9:0] O_HALT = 10'b0_0_0_1_1_0_00_0_1;

    vec_t tbl[$];
    int checks = 0;
    int passed = 0;
    int step = 0;

    task automatic apply(input logic [7:0] in);
        {rst_n, hd_stall, ex_branch_taken, ex_overflow, ex_mdu_start, ex_mdu_is_div, id_halt, resume} = in;
    endtask

    task automatic check(input int id, input logic [9:0] o, input logic e);
        logic [10:0] act;
        act = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble,
               pc_sel, mdu_done, halted, exc_flag};
        checks++;
        if (act === {o, e}) passed++;
        else $display("FAIL step %0d: got %b want %b", id, act, {o, e});
    endtask

    task automatic run_step(input logic [7:0] in, input logic [9:0] o, input logic e);
        @(negedge clk);
        apply(in);
        #1;
        check(step, o, e);
        step++;
    endtask

    initial begin
        apply(8'b0);
        // T1 reset with junk inputs, then first RUN cycle
        tbl.push_back('{8'b0_1_1_1_1_0_1_1, O_RST, 1'b0});
        tbl.push_back('{8'b0_0_1_0_1_1_0_1, O_RST, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_RUN, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_1, O_RUN, 1'b0});
        // T2 MUL: freeze cycles 0-2, done cycle 3; inputs ignored meanwhile
        tbl.push_back('{8'b1_0_0_0_1_0_0_0, O_FRZ,  1'b0});
        tbl.push_back('{8'b1_1_1_1_0_0_1_0, O_FRZ,  1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_FRZ,  1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_DONE, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_RUN,  1'b0});
        // mdu_start + id_halt: MDU first, HALT after release
        tbl.push_back('{8'b1_0_0_0_1_0_1_0, O_FRZ,  1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_1_0, O_FRZ,  1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_1_0, O_FRZ,  1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_1_0, O_DONE, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_1_0, O_STL,  1'b0});
        // T6 halted five cycles, resume on the fifth, other inputs ignored
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_HALT, 1'b0});
        tbl.push_back('{8'b1_1_1_1_1_0_0_0, O_HALT, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_HALT, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_HALT, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_1, O_HALT, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_RUN,  1'b0});
        // T5 branch beats hd_stall; hd_stall alone stalls; halt beats hd_stall
        tbl.push_back('{8'b1_1_1_0_0_0_0_0, O_BR,   1'b0});
        tbl.push_back('{8'b1_1_0_0_0_0_0_0, O_STL,  1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_RUN,  1'b0});
        tbl.push_back('{8'b1_1_0_0_0_0_1_0, O_STL,  1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_1, O_HALT, 1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_RUN,  1'b0});
        // T4 overflow + branch: exception wins, exc_flag sticky
        tbl.push_back('{8'b1_0_1_1_0_0_0_0, O_EXC,  1'b0});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_RUN,  1'b1});
        tbl.push_back('{8'b1_0_0_0_1_0_0_0, O_FRZ,  1'b1});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_FRZ,  1'b1});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_FRZ,  1'b1});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_DONE, 1'b1});
        tbl.push_back('{8'b1_0_0_1_1_0_0_0, O_EXC,  1'b1});
        tbl.push_back('{8'b1_0_0_0_0_0_0_0, O_RUN,  1'b1});
        foreach (tbl[i]) run_step(tbl[i].in, tbl[i].o, tbl[i].e);

        // T3 DIV aborted by reset in its fifth freeze cycle; no mdu_done may follow
        run_step(8'b1_0_0_0_1_1_0_0, O_FRZ, 1'b1);
        for (int i = 1; i < 4; i++) run_step(8'b1_0_0_0_0_0_0_0, O_FRZ, 1'b1);
        run_step(8'b0_0_0_0_0_0_0_0, O_RST, 1'b1);
        run_step(8'b0_0_0_0_0_0_0_0, O_RST, 1'b0);
        for (int i = 0; i < 10; i++) run_step(8'b1_0_0_0_0_0_0_0, O_RUN, 1'b0);
        // MUL after the aborted DIV must still take exactly four cycles
        run_step(8'b1_0_0_0_1_0_0_0, O_FRZ, 1'b0);
        run_step(8'b1_0_0_0_0_0_0_0, O_FRZ, 1'b0);
        run_step(8'b1_0_0_0_0_0_0_0, O_FRZ, 1'b0);
        run_step(8'b1_0_0_0_0_0_0_0, O_DONE, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
